// File: rtl/tick_timer_pkg.sv
// tick_timer_pkg: shared state encoding and default width for the tick countdown timer
package tick_timer_pkg;
  localparam int CNT_W_DEF = 7;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HOLD   = 2'd2,
    EXPIRE = 2'd3
  } state_t;
endpackage

// File: rtl/edge_sync_pulse.sv
// edge_sync_pulse: synchronizes an asynchronous level and emits a one-cycle pulse per rising edge
module edge_sync_pulse #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic pulse
);
  logic [SYNC_STAGES-1:0] sync;
  logic prev;
  always_ff @(posedge clk)
    if (rst) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], async_in};
      prev <= sync[SYNC_STAGES-1];
    end
  // both operands are flops, so the pulse cannot glitch
  assign pulse = sync[SYNC_STAGES-1] & ~prev;
endmodule

// File: rtl/tick_countdown_timer.sv
// tick_countdown_timer: loadable down-counter advanced by rising edges of divided_clk
module tick_countdown_timer
  import tick_timer_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             divided_clk,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             start,
  input  logic             pause,
  output logic [CNT_W-1:0] count,
  output logic             running,
  output logic             done,
  output logic             tick
);
  state_t state;
  edge_sync_pulse #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk(clk),
    .rst(rst),
    .async_in(divided_clk),
    .pulse(tick)
  );
  always_ff @(posedge clk)
    if (rst) begin
      count <= '0;
      state <= IDLE;
    end else if (load) begin
      count <= load_val;
      state <= IDLE;
    end else
      unique case (state)
        IDLE: if (start) state <= (count != '0) ? RUN : EXPIRE;
        RUN:
          if (pause) state <= HOLD;
          else if (tick) begin
            count <= (count > CNT_W'(1)) ? count - CNT_W'(1) : '0;
            state <= (count > CNT_W'(1)) ? RUN : EXPIRE;
          end
        HOLD: if (start && !pause) state <= RUN;
        EXPIRE: state <= IDLE;
      endcase
  assign running = (state == RUN);
  assign done    = (state == EXPIRE);
endmodule

// File: tb/tb_tick_countdown_timer.sv
// tb_tick_countdown_timer: directed vector table plus hand sequences for the countdown timer
module tb_tick_countdown_timer;
  logic clk = 1'b0, rst = 1'b1, divided_clk = 1'b0, load = 1'b0, start = 1'b0, pause = 1'b0;
  logic [6:0] load_val = '0, count;
  logic running, done, tick;
  int checks = 0, errors = 0;

  typedef struct {
    logic       ld;
    logic [6:0] lv;
    logic       st;
    logic       pa;
    logic       dc;
    logic [6:0] e_count;
    logic       e_run;
    logic       e_done;
    logic       e_tick;
  } vec_t;
  vec_t vecs [11];

  tick_countdown_timer dut (
    .clk(clk), .rst(rst), .divided_clk(divided_clk), .load(load), .load_val(load_val),
    .start(start), .pause(pause), .count(count), .running(running), .done(done), .tick(tick)
  );

  always #5 clk = ~clk;

  // inputs change at negedge, outputs are sampled at the following negedge
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string name, input int c, input int r, input int d);
    chk({name, " count"}, int'(count), c);
    chk({name, " running"}, int'(running), r);
    chk({name, " done"}, int'(done), d);
  endtask

  // leaves a tick pending for the next cycle
  task automatic pulse_dclk();
    divided_clk = 1'b1;
    cyc();
    divided_clk = 1'b0;
    cyc();
    chk("tick pending", int'(tick), 1);
  endtask

  initial begin
    vecs[0]  = '{1'b1, 7'd3, 1'b0, 1'b0, 1'b0, 7'd3, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 7'd0, 1'b1, 1'b0, 1'b0, 7'd3, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 7'd0, 1'b0, 1'b0, 1'b1, 7'd3, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 7'd0, 1'b0, 1'b0, 1'b1, 7'd3, 1'b1, 1'b0, 1'b1};
    vecs[4]  = '{1'b0, 7'd0, 1'b0, 1'b0, 1'b0, 7'd2, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 7'd0, 1'b0, 1'b0, 1'b1, 7'd2, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 7'd0, 1'b0, 1'b0, 1'b0, 7'd2, 1'b1, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 7'd0, 1'b0, 1'b0, 1'b1, 7'd1, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 7'd0, 1'b0, 1'b0, 1'b0, 7'd1, 1'b1, 1'b0, 1'b1};
    vecs[9]  = '{1'b0, 7'd0, 1'b0, 1'b0, 1'b0, 7'd0, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 7'd0, 1'b0, 1'b0, 1'b0, 7'd0, 1'b0, 1'b0, 1'b0};

    @(negedge clk);
    divided_clk = 1'b1;
    cyc();
    divided_clk = 1'b0;
    cyc();
    chk_all("reset", 0, 0, 0);
    chk("reset tick", int'(tick), 0);
    rst = 1'b0;
    cyc();
    cyc();
    chk("post-reset tick", int'(tick), 0);

    // basic countdown 3->0 with rising and falling divided_clk edges
    for (int i = 0; i < 11; i++) begin
      load = vecs[i].ld;
      load_val = vecs[i].lv;
      start = vecs[i].st;
      pause = vecs[i].pa;
      divided_clk = vecs[i].dc;
      cyc();
      chk($sformatf("vec%0d count", i), int'(count), int'(vecs[i].e_count));
      chk($sformatf("vec%0d running", i), int'(running), int'(vecs[i].e_run));
      chk($sformatf("vec%0d done", i), int'(done), int'(vecs[i].e_done));
      chk($sformatf("vec%0d tick", i), int'(tick), int'(vecs[i].e_tick));
    end

    // pause with a coincident tick, ignored ticks in HOLD, resume
    load = 1'b1; load_val = 7'd5; start = 1'b1;
    cyc();
    chk_all("load5 with start", 5, 0, 0);
    load = 1'b0;
    cyc();
    start = 1'b0;
    chk_all("start5", 5, 1, 0);
    pulse_dclk(); cyc();
    chk_all("run tick1", 4, 1, 0);
    start = 1'b1;
    pulse_dclk(); cyc();
    start = 1'b0;
    chk_all("run tick2 start noop", 3, 1, 0);
    pulse_dclk();
    pause = 1'b1;
    cyc();
    chk_all("pause drops tick", 3, 0, 0);
    pause = 1'b0;
    pulse_dclk(); cyc();
    chk_all("hold ignores tick", 3, 0, 0);
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk_all("resume", 3, 1, 0);
    for (int k = 2; k >= 1; k--) begin
      pulse_dclk(); cyc();
      chk_all("resume tick", k, 1, 0);
    end
    pulse_dclk(); cyc();
    chk_all("resume expire", 0, 0, 1);
    cyc();
    chk_all("resume idle", 0, 0, 0);

    // load aborts a run without done
    load = 1'b1; load_val = 7'd4;
    cyc();
    load = 1'b0; start = 1'b1;
    cyc();
    start = 1'b0;
    chk_all("run at 4", 4, 1, 0);
    load = 1'b1; load_val = 7'd9;
    cyc();
    load = 1'b0;
    chk_all("reload 9", 9, 0, 0);
    cyc();
    chk_all("reload idle", 9, 0, 0);

    // start at zero fires done immediately
    load = 1'b1; load_val = 7'd0;
    cyc();
    load = 1'b0; start = 1'b1;
    cyc();
    start = 1'b0;
    chk_all("zero start", 0, 0, 1);
    cyc();
    chk_all("zero after", 0, 0, 0);

    // reset mid-run
    load = 1'b1; load_val = 7'd6;
    cyc();
    load = 1'b0; start = 1'b1;
    cyc();
    start = 1'b0;
    pulse_dclk(); cyc();
    chk_all("pre-reset run", 5, 1, 0);
    rst = 1'b1; load = 1'b1; load_val = 7'd7; start = 1'b1;
    cyc();
    chk_all("mid-run reset", 0, 0, 0);
    rst = 1'b0; load = 1'b0; start = 1'b0;
    cyc();
    chk_all("after mid-run reset", 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
